// File: rtl/outr_window_avg.sv
// Sliding window of the last 2^L signed samples: exact sum, floor-average,
// minimum and maximum, registered one cycle after each accepted sample.
module outr_window_avg #(
  parameter int W = 18,
  parameter int L = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic signed [W-1:0]   inR,
  input  logic                  inValid,
  input  logic                  CLR,
  output logic signed [W+L-1:0] sumR,
  output logic signed [W-1:0]   avgR,
  output logic signed [W-1:0]   minR,
  output logic signed [W-1:0]   maxR,
  output logic                  full,
  output logic                  outValid
);

  localparam int N = 1 << L;

  logic signed [W-1:0]   r_win [N];
  logic [L:0]            r_cnt;
  logic signed [W+L-1:0] r_acc;
  logic                  r_p1;

  logic                  w_full;
  logic signed [W+L-1:0] w_sub;
  logic signed [W+L-1:0] w_in;
  logic signed [W+L-1:0] w_avg;
  logic signed [W-1:0]   w_min;
  logic signed [W-1:0]   w_max;

  assign w_full = (r_cnt == (L+1)'(N));
  assign full   = w_full;

  always_comb begin
    w_in  = (W+L)'(inR);
    w_sub = '0;
    if (w_full) w_sub = (W+L)'(r_win[N-1]);
    w_avg = r_acc >>> L;
    w_min = r_win[0];
    w_max = r_win[0];
    // Only filled entries take part; win[0] is always filled when p1 is set
    for (int i = 1; i < N; i++) begin
      if (i < int'(r_cnt)) begin
        if (r_win[i] < w_min) w_min = r_win[i];
        if (r_win[i] > w_max) w_max = r_win[i];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N; i++) r_win[i] <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_p1     <= 1'b0;
      sumR     <= '0;
      avgR     <= '0;
      minR     <= '0;
      maxR     <= '0;
      outValid <= 1'b0;
    end else if (CLR) begin
      for (int i = 0; i < N; i++) r_win[i] <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_p1     <= 1'b0;
      outValid <= 1'b0;
    end else begin
      r_p1 <= inValid;
      if (inValid) begin
        r_win[0] <= inR;
        for (int i = 1; i < N; i++) r_win[i] <= r_win[i-1];
        r_acc <= r_acc + w_in - w_sub;
        if (!w_full) r_cnt <= r_cnt + 1'b1;
      end
      if (r_p1) begin
        sumR     <= r_acc;
        avgR     <= w_avg[W-1:0];
        minR     <= w_min;
        maxR     <= w_max;
        outValid <= w_full;
      end else begin
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_outr_window_avg.sv
// Directed bench for outr_window_avg: expected windows are queued by the
// stimulus and consumed by a monitor on every outValid strobe.
module tb_outr_window_avg;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic signed [17:0] inR = '0;
  logic               inValid = 1'b0;
  logic               CLR = 1'b0;
  logic signed [19:0] sumR;
  logic signed [17:0] avgR;
  logic signed [17:0] minR;
  logic signed [17:0] maxR;
  logic               full;
  logic               outValid;

  typedef struct packed {
    logic [19:0] s;
    logic [17:0] a;
    logic [17:0] mn;
    logic [17:0] mx;
  } exp_t;

  exp_t q[$];
  int assertions = 0;
  int failures = 0;
  int ov_cnt = 0;

  outr_window_avg #(.W(18), .L(2)) dut (
    .CLK(CLK), .RST(RST), .inR(inR), .inValid(inValid), .CLR(CLR),
    .sumR(sumR), .avgR(avgR), .minR(minR), .maxR(maxR),
    .full(full), .outValid(outValid)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    assertions++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_win(input int s, input int a, input int mn, input int mx);
    exp_t e;
    e.s  = s[19:0];
    e.a  = a[17:0];
    e.mn = mn[17:0];
    e.mx = mx[17:0];
    q.push_back(e);
  endtask

  task automatic drive(input int x);
    @(negedge CLK);
    inR = x[17:0];
    inValid = 1'b1;
    CLR = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      inValid = 1'b0;
      CLR = 1'b0;
    end
  endtask

  task automatic clear();
    @(negedge CLK);
    inValid = 1'b0;
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  task automatic settle();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every strobe must match the oldest queued window
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (outValid) begin
      ov_cnt++;
      if (q.size() == 0) begin
        assertions++;
        failures++;
        $display("FAIL unexpected_outValid: got 1 expected 0 (sumR=%0d)", sumR);
      end else begin
        e = q.pop_front();
        chk("sb_sumR", int'(sumR), int'($signed(e.s)));
        chk("sb_avgR", int'(avgR), int'($signed(e.a)));
        chk("sb_minR", int'(minR), int'($signed(e.mn)));
        chk("sb_maxR", int'(maxR), int'($signed(e.mx)));
      end
    end
  end

  initial begin
    int ov0;
    int guard;
    #1;
    chk("rst_sumR", int'(sumR), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_outValid", int'(outValid), 0);
    @(negedge CLK);
    RST = 1'b0;

    // Fill and slide
    drive(10); drive(20); drive(30);
    settle();
    chk("full_after3", int'(full), 0);
    expect_win(100, 25, 10, 40);
    drive(40);
    settle();
    chk("full_after4", int'(full), 1);
    expect_win(140, 35, 20, 50);
    drive(50);
    idle(3);

    // Mid-stream reset between edges, with a sample in flight
    drive(60);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst_sumR", int'(sumR), 0);
    chk("arst_avgR", int'(avgR), 0);
    chk("arst_minR", int'(minR), 0);
    chk("arst_maxR", int'(maxR), 0);
    chk("arst_full", int'(full), 0);
    chk("arst_outValid", int'(outValid), 0);
    @(negedge CLK);
    inValid = 1'b0;
    RST = 1'b0;

    // Partial window after reset
    drive(5); drive(6); drive(7);
    idle(1);
    settle();
    chk("part_full", int'(full), 0);
    chk("part_outValid", int'(outValid), 0);
    chk("part_sumR", int'(sumR), 18);
    chk("part_minR", int'(minR), 5);
    chk("part_maxR", int'(maxR), 7);
    clear();
    settle();
    chk("clr_hold_sumR", int'(sumR), 18);
    chk("clr_full", int'(full), 0);

    // Negative rounding
    drive(-1); drive(-1); drive(-1);
    expect_win(-5, -2, -2, -1);
    drive(-2);
    idle(2);

    // Extremes
    clear();
    drive(131071); drive(131071); drive(131071);
    expect_win(524284, 131071, 131071, 131071);
    drive(131071);
    idle(2);
    clear();
    drive(-131072); drive(-131072); drive(-131072);
    expect_win(-524288, -131072, -131072, -131072);
    drive(-131072);
    idle(2);

    // Gaps
    clear();
    drive(1); idle(1);
    drive(2); idle(2);
    drive(3);
    expect_win(10, 2, 1, 4);
    drive(4);
    idle(4);
    settle();
    chk("gap_hold_sumR", int'(sumR), 10);
    chk("gap_outValid", int'(outValid), 0);
    expect_win(17, 4, 2, 8);
    drive(8);
    idle(2);

    // CLR together with a sample: the 7 is dropped
    @(negedge CLK);
    inR = 18'sd7;
    inValid = 1'b1;
    CLR = 1'b1;
    @(negedge CLK);
    inValid = 1'b0;
    CLR = 1'b0;
    chk("clrdrop_full", int'(full), 0);
    drive(1); drive(2); drive(3);
    settle();
    chk("clrdrop_full3", int'(full), 0);
    expect_win(10, 2, 1, 4);
    drive(4);
    idle(2);

    // Back-to-back 1..8
    clear();
    ov0 = ov_cnt;
    for (int i = 1; i <= 8; i++) begin
      if (i >= 4) expect_win(4*i - 6, (4*i - 6) >>> 2, i - 3, i);
      drive(i);
    end
    idle(3);
    chk("b2b_strobes", ov_cnt - ov0, 5);
    chk("b2b_sumR", int'(sumR), 26);
    chk("b2b_minR", int'(minR), 5);
    chk("b2b_maxR", int'(maxR), 8);

    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    chk("sb_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertions, failures);
    $finish;
  end

endmodule
